// File: rtl/systolic_result_drain_if.sv
// rtl/systolic_result_drain_if.sv - result beat stream from the drain to write-back
interface systolic_result_drain_if #(
  parameter int OUT_WIDTH = 16,
  parameter int IDX_W     = 2
);
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_last;
  logic                 out_sat;

  modport master (output out_valid, out_data, out_idx, out_last, out_sat, input out_ready);
  modport slave  (input out_valid, out_data, out_idx, out_last, out_sat, output out_ready);
endinterface

// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - snapshot the PE column accumulators and stream them scaled/saturated
module systolic_result_drain #(
  parameter int  NUM_PE    = 4,
  parameter int  ACC_WIDTH = 24,
  parameter int  OUT_WIDTH = 16,
  parameter int  SHIFT     = 0,
  localparam int IDX_W     = $clog2(NUM_PE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        capture_i,
  input  logic [NUM_PE*ACC_WIDTH-1:0] acc_bus_i,
  output logic                        busy_o,
  output logic                        capture_drop_o,
  systolic_result_drain_if.master     out_if
);
  typedef enum logic {IDLE, STREAM} state_e;

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_PE - 1);
  localparam logic [ACC_WIDTH:0] SAT_LIMIT = {{ACC_WIDTH{1'b0}}, 1'b1} << OUT_WIDTH;

  // Returns {saturated, word}; the extra top bit keeps the limit compare valid when OUT_WIDTH == ACC_WIDTH.
  function automatic logic [OUT_WIDTH:0] scale_sat(input logic [ACC_WIDTH-1:0] word);
    logic [ACC_WIDTH:0] shifted;
    shifted = {1'b0, word >> SHIFT};
    if (shifted >= SAT_LIMIT) return {1'b1, {OUT_WIDTH{1'b1}}};
    return {1'b0, shifted[OUT_WIDTH-1:0]};
  endfunction

  state_e                 state_q;
  logic                   busy_q;
  logic                   drop_q;
  logic                   valid_q;
  logic [OUT_WIDTH-1:0]   data_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   last_q;
  logic                   sat_q;
  logic [ACC_WIDTH-1:0]   snap_q [NUM_PE];

  logic                   xfer;
  logic                   load;
  logic [IDX_W-1:0]       next_idx_d;
  logic [OUT_WIDTH:0]     next_beat_d;
  logic [OUT_WIDTH:0]     first_beat_d;

  assign xfer         = valid_q && out_if.out_ready;
  assign load         = (state_q == IDLE) && capture_i;
  assign next_idx_d   = idx_q + 1'b1;
  assign next_beat_d  = scale_sat(snap_q[next_idx_d]);
  assign first_beat_d = scale_sat(acc_bus_i[0 +: ACC_WIDTH]);

  always_ff @(posedge clk) begin
    if (!reset && load) begin
      for (int k = 0; k < NUM_PE; k++) begin
        snap_q[k] <= acc_bus_i[k*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (capture_i) begin
            state_q <= STREAM;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            idx_q   <= '0;
            last_q  <= 1'b0;
            sat_q   <= first_beat_d[OUT_WIDTH];
            data_q  <= first_beat_d[OUT_WIDTH-1:0];
          end
        end
        STREAM: begin
          drop_q <= capture_i;
          if (xfer) begin
            if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              idx_q   <= '0;
              last_q  <= 1'b0;
              sat_q   <= 1'b0;
              data_q  <= '0;
            end else begin
              idx_q   <= next_idx_d;
              last_q  <= (next_idx_d == LAST_IDX);
              sat_q   <= next_beat_d[OUT_WIDTH];
              data_q  <= next_beat_d[OUT_WIDTH-1:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign capture_drop_o   = drop_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_idx   = idx_q;
  assign out_if.out_last  = last_q;
  assign out_if.out_sat   = sat_q;
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb/tb_systolic_result_drain.sv - self-checking bench for systolic_result_drain
module tb_systolic_result_drain;
  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  idx;
    logic        last;
    logic        sat;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cap0, cap8, rdy0, rdy8;
  logic [95:0] bus0, bus8;
  logic        busy0, busy8, drop0, drop8;
  int          checks = 0;
  int          errors = 0;

  beat_t q0[$];
  beat_t q8[$];
  bit    xd0, xd8;

  always #5 clk = ~clk;

  systolic_result_drain_if #(.OUT_WIDTH(16), .IDX_W(2)) if0 ();
  systolic_result_drain_if #(.OUT_WIDTH(16), .IDX_W(2)) if8 ();
  assign if0.out_ready = rdy0;
  assign if8.out_ready = rdy8;

  systolic_result_drain #(.NUM_PE(4), .ACC_WIDTH(24), .OUT_WIDTH(16), .SHIFT(0)) dut0 (
    .clk(clk), .reset(rst), .capture_i(cap0), .acc_bus_i(bus0),
    .busy_o(busy0), .capture_drop_o(drop0), .out_if(if0));
  systolic_result_drain #(.NUM_PE(4), .ACC_WIDTH(24), .OUT_WIDTH(16), .SHIFT(8)) dut8 (
    .clk(clk), .reset(rst), .capture_i(cap8), .acc_bus_i(bus8),
    .busy_o(busy8), .capture_drop_o(drop8), .out_if(if8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk_beat(input logic [23:0] w, input int sh, input int k);
    beat_t       b;
    logic [23:0] v;
    v = w >> sh;
    if (v > 24'd65535) begin
      b.data = 16'hFFFF;
      b.sat  = 1'b1;
    end else begin
      b.data = v[15:0];
      b.sat  = 1'b0;
    end
    b.idx  = k[1:0];
    b.last = (k == 3);
    return b;
  endfunction

  // Queue model: a snapshot is a list of pending beats; busy means the list is non-empty.
  always @(posedge clk) begin
    bit wb0, wb8;
    if (rst) begin
      q0.delete();
      q8.delete();
      xd0 = 1'b0;
      xd8 = 1'b0;
    end else begin
      wb0 = (q0.size() != 0);
      wb8 = (q8.size() != 0);
      xd0 = cap0 && wb0;
      xd8 = cap8 && wb8;
      if (wb0 && rdy0) void'(q0.pop_front());
      if (wb8 && rdy8) void'(q8.pop_front());
      if (!wb0 && cap0) for (int k = 0; k < 4; k++) q0.push_back(mk_beat(bus0[k*24 +: 24], 0, k));
      if (!wb8 && cap8) for (int k = 0; k < 4; k++) q8.push_back(mk_beat(bus8[k*24 +: 24], 8, k));
    end
  end

  task automatic cmp_dut(input string t, input logic v, input logic b, input logic d,
                         input logic [15:0] data, input logic [1:0] idx, input logic last,
                         input logic sat, input bit eb, input bit ed, input beat_t f);
    chk({t, "_valid"}, v, eb);
    chk({t, "_busy"}, b, eb);
    chk({t, "_drop"}, d, ed);
    if (eb) begin
      chk({t, "_data"}, data, f.data);
      chk({t, "_idx"}, idx, f.idx);
      chk({t, "_last"}, last, f.last);
      chk({t, "_sat"}, sat, f.sat);
    end else begin
      chk({t, "_idle_idx"}, idx, 2'd0);
    end
  endtask

  always @(negedge clk) begin
    beat_t f0, f8;
    f0 = '0;
    f8 = '0;
    if (q0.size() != 0) f0 = q0[0];
    if (q8.size() != 0) f8 = q8[0];
    cmp_dut("d0", if0.out_valid, busy0, drop0, if0.out_data, if0.out_idx, if0.out_last,
            if0.out_sat, q0.size() != 0, xd0, f0);
    cmp_dut("d8", if8.out_valid, busy8, drop8, if8.out_data, if8.out_idx, if8.out_last,
            if8.out_sat, q8.size() != 0, xd8, f8);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain0();
    int n = 0;
    while (busy0 && n < 50) begin
      step();
      n++;
    end
    chk("drain0_timeout", busy0, 1'b0);
  endtask

  logic [15:0] t1_data [4] = '{16'h0010, 16'hFFFF, 16'hFFFF, 16'hFFFF};
  logic [3:0]  t1_sat      = 4'b1100;
  logic [15:0] t4_data [4] = '{16'h1234, 16'hFFFF, 16'h0100, 16'hFFFF};
  logic [3:0]  rdy_pat     = 4'b1001;

  initial begin
    int seen [$];
    int c;
    rst = 1'b1; cap0 = 1'b0; cap8 = 1'b0; rdy0 = 1'b1; rdy8 = 1'b1;
    bus0 = '0; bus8 = '0;
    step(); step();
    chk("rst_valid", if0.out_valid, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_data", if0.out_data, 16'h0);
    rst = 1'b0;
    step();

    // Directed case 1: mixed saturation, ready held high.
    bus0 = {24'hFFFFFF, 24'h010000, 24'h00FFFF, 24'h000010};
    cap0 = 1'b1; step(); cap0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t1_data", if0.out_data, t1_data[k]);
      chk("t1_sat", if0.out_sat, t1_sat[k]);
      chk("t1_idx", if0.out_idx, k[1:0]);
      chk("t1_last", if0.out_last, k == 3);
      chk("t1_busy", busy0, 1'b1);
      step();
    end
    chk("t1_busy_low_cycle5", busy0, 1'b0);
    chk("t1_valid_low", if0.out_valid, 1'b0);
    step();

    // Directed case 2: ready toggling 1,0,0,1.
    cap0 = 1'b1; step(); cap0 = 1'b0;
    c = 0;
    while (busy0 && c < 40) begin
      rdy0 = rdy_pat[c % 4];
      if (if0.out_valid && rdy0) seen.push_back(int'(if0.out_idx));
      step();
      c++;
    end
    rdy0 = 1'b1;
    chk("t2_timeout", busy0, 1'b0);
    chk("t2_beats", seen.size(), 4);
    for (int k = 0; k < seen.size() && k < 4; k++) chk("t2_order", seen[k], k);
    step();

    // Directed case 3: capture during stream and on the final transfer.
    cap0 = 1'b1; step(); cap0 = 1'b0;
    step();
    chk("t3_idx1", if0.out_idx, 2'd1);
    cap0 = 1'b1; step(); cap0 = 1'b0;
    chk("t3_drop1", drop0, 1'b1);
    chk("t3_data2", if0.out_data, 16'hFFFF);
    step();
    chk("t3_drop_clear", drop0, 1'b0);
    chk("t3_last", if0.out_last, 1'b1);
    cap0 = 1'b1; step(); cap0 = 1'b0;
    chk("t3_drop2", drop0, 1'b1);
    chk("t3_idle", busy0, 1'b0);
    step();
    chk("t3_no_restart", busy0, 1'b0);

    // Directed case 4: SHIFT=8 instance.
    bus8 = {24'hFFFFFF, 24'h010000, 24'hFFFFFF, 24'h123456};
    cap8 = 1'b1; step(); cap8 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t4_data", if8.out_data, t4_data[k]);
      chk("t4_sat", if8.out_sat, 1'b0);
      step();
    end
    chk("t4_done", busy8, 1'b0);

    // Directed case 5: reset mid-stream at idx2, then a fresh snapshot.
    bus0 = {24'h000040, 24'h000030, 24'h000020, 24'h000010};
    cap0 = 1'b1; step(); cap0 = 1'b0;
    step(); step();
    chk("t5_idx2", if0.out_idx, 2'd2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_valid", if0.out_valid, 1'b0);
    chk("t5_busy", busy0, 1'b0);
    chk("t5_data", if0.out_data, 16'h0);
    chk("t5_idx", if0.out_idx, 2'd0);
    chk("t5_last", if0.out_last, 1'b0);
    chk("t5_sat", if0.out_sat, 1'b0);
    bus0 = {24'h000003, 24'h000002, 24'h000001, 24'h123456};
    cap0 = 1'b1; step(); cap0 = 1'b0;
    chk("t5_fresh_idx", if0.out_idx, 2'd0);
    chk("t5_fresh_data", if0.out_data, 16'hFFFF);
    chk("t5_fresh_sat", if0.out_sat, 1'b1);
    drain0();
    step();

    // Directed case 6: bus changes right after the capture edge.
    bus0 = {24'h000400, 24'h000300, 24'h000200, 24'h000100};
    cap0 = 1'b1; step(); cap0 = 1'b0;
    bus0 = {4{24'hABCDEF}};
    chk("t6_word0", if0.out_data, 16'h0100);
    step();
    chk("t6_word1", if0.out_data, 16'h0200);
    drain0();
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
